adder: RTL and testbench

- Registered 16-bit two-operand carry-lookahead adder, one cycle of latency.
- Hierarchical lookahead: 4-bit groups, each producing sum bits plus group propagate/generate. A second-level lookahead unit combines the four groups into group carries and the final carry-out.
- Used as a datapath arithmetic primitive; the result is registered so it can sit directly on a pipeline stage boundary.

---
 rtl/adder_pkg.sv | 31 +++
 rtl/cla_group4.sv | 27 ++
 rtl/adder.sv | 73 +++++++
 tb/tb_adder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared widths, types and the 4-way carry-lookahead function used at both
// the bit-group level and the group-combining level of the adder.
package adder_pkg;

    localparam int ADDER_WIDTH = 16;
    localparam int ADDER_GROUP = 4;

    typedef logic [15:0] word_t;
    typedef logic [3:0]  nib_t;

    // c[i] is the carry into position i; pg/gg summarise the whole block.
    typedef struct packed {
        nib_t c;
        logic pg;
        logic gg;
    } la_t;

    function automatic la_t lookahead4(input nib_t p, input nib_t g, input logic cin);
        la_t r;
        r.c[0] = cin;
        r.c[1] = g[0] | (p[0] & cin);
        r.c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        r.c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);
        r.pg   = &p;
        r.gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);
        return r;
    endfunction

endpackage

// File: rtl/cla_group4.sv
// One 4-bit lookahead group: sum bits for its slice plus the group
// propagate/generate consumed by the second-level lookahead.
module cla_group4
    import adder_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       pg,
    output logic       gg
);

    nib_t p;
    nib_t g;
    la_t  la;

    assign p  = a | b;
    assign g  = a & b;
    assign la = lookahead4(p, g, cin);

    // Carries come straight from the lookahead terms, never from a ripple.
    assign sum = a ^ b ^ la.c;
    assign pg  = la.pg;
    assign gg  = la.gg;

endmodule

// File: rtl/adder.sv
// Registered 16-bit two-level carry-lookahead adder, one cycle of latency.
// Optional carry-in port is enabled by defining ADDER_CIN_EN.
module adder
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH,
    parameter int GROUP = ADDER_GROUP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef ADDER_CIN_EN
    input  logic             cin,
`endif
    output logic [WIDTH-1:0] answer,
    output logic             cout,
    output logic             out_valid
);

    if (WIDTH != 16 || WIDTH != GROUP * GROUP) begin : g_bad_width
        $error("adder: WIDTH must be 16 and equal GROUP*GROUP");
    end

    logic       cin0;
    nib_t       grp_pg;
    nib_t       grp_gg;
    nib_t       grp_cin;
    word_t      sum;
    logic       sum_cout;
    la_t        top_la;

`ifdef ADDER_CIN_EN
    assign cin0 = cin;
`else
    assign cin0 = 1'b0;
`endif

    for (genvar gi = 0; gi < 4; gi++) begin : g_grp
        cla_group4 u_grp (
            .a   (a[gi*4 +: 4]),
            .b   (b[gi*4 +: 4]),
            .cin (grp_cin[gi]),
            .sum (sum[gi*4 +: 4]),
            .pg  (grp_pg[gi]),
            .gg  (grp_gg[gi])
        );
    end

    // Second level: the same lookahead applied to group PG/GG.
    assign top_la   = lookahead4(grp_pg, grp_gg, cin0);
    assign grp_cin  = top_la.c;
    assign sum_cout = top_la.gg | (top_la.pg & cin0);

    // Handshake: in_valid=1 at a rising edge captures a/b; out_valid is high
    // for exactly the cycle after that edge. No backpressure (always ready).
    // Without in_valid the result registers hold, so X on a/b cannot leak in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            answer    <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                answer <= sum;
                cout   <= sum_cout;
            end
        end
    end

endmodule

// File: tb/tb_adder.sv
// Self-checking bench for adder: randomized and directed vectors against an
// arithmetic reference (exact 17-bit sum). Covers ADDER_CIN_EN when defined.
module tb_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] answer;
    logic        cout;
    logic        out_valid;

    int n_cmp;
    int n_err;
    logic [16:0] exp_q[$];

    adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
`ifdef ADDER_CIN_EN
        .cin       (cin),
`endif
        .answer    (answer),
        .cout      (cout),
        .out_valid (out_valid)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact unsigned sum, carry-in only exists in the cin build.
    function automatic logic [16:0] ref_sum(input logic [15:0] x, input logic [15:0] y,
                                            input logic ci);
        int unsigned s;
`ifdef ADDER_CIN_EN
        s = int'(x) + int'(y) + int'(ci);
`else
        s = int'(x) + int'(y) + 0 * int'(ci);
`endif
        return s[16:0];
    endfunction

    // Driver: present inputs away from the edge, then wait past the edge.
    task automatic drive(input logic v, input logic [15:0] x, input logic [15:0] y,
                         input logic ci);
        @(negedge clk);
        in_valid = v;
        a        = x;
        b        = y;
        cin      = ci;
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string name, input logic [16:0] exp, input logic exp_v);
        n_cmp++;
        if ({cout, answer} !== exp || out_valid !== exp_v) begin
            n_err++;
            $display("FAIL %s: got cout=%0b answer=%h out_valid=%0b, want cout=%0b answer=%h out_valid=%0b",
                     name, cout, answer, out_valid, exp[16], exp[15:0], exp_v);
        end
    endtask

    task automatic test_reset();
        drive(1'b1, 16'h0F0F, 16'h0101, 1'b0);
        check_result("pre_reset_load", 17'h01010, 1'b1);
        // Asynchronous assert mid-cycle must clear outputs without a clock edge.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_result("async_reset_clear", 17'h0, 1'b0);
        in_valid = 1'b1;
        a = 16'h1234;
        b = 16'h1111;
        repeat (3) @(posedge clk);
        #1;
        check_result("reset_hold", 17'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 16'h1234, 16'h1111, 1'b0);
        check_result("after_release", 17'h02345, 1'b1);
    endtask

    task automatic test_random();
        logic [15:0] x;
        logic [15:0] y;
        logic [16:0] e;
        for (int i = 0; i < 100; i++) begin
            x = 16'($urandom_range(0, 32767));
            y = 16'($urandom_range(0, 32767));
            drive(1'b1, x, y, 1'b0);
            e = ref_sum(x, y, 1'b0);
            if (e[16] !== 1'b0) $display("note: unexpected carry in reference");
            check_result("random", e, 1'b1);
        end
    endtask

    task automatic test_carry_chain();
        drive(1'b1, 16'hFFFF, 16'h0001, 1'b0);
        check_result("carry_full_chain", 17'h10000, 1'b1);
        drive(1'b1, 16'h0FFF, 16'h0001, 1'b0);
        check_result("carry_cross_group", 17'h01000, 1'b1);
        drive(1'b1, 16'h00FF, 16'h0001, 1'b0);
        check_result("carry_two_groups", 17'h00100, 1'b1);
    endtask

    task automatic test_maximum();
        drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
        check_result("max_operands", 17'h1FFFE, 1'b1);
        drive(1'b1, 16'h0000, 16'h0000, 1'b0);
        check_result("zero_operands", 17'h00000, 1'b1);
    endtask

    task automatic test_valid_gating();
        drive(1'b1, 16'h0005, 16'h0003, 1'b0);
        check_result("gate_load", 17'h00008, 1'b1);
        drive(1'b0, 16'hAAAA, 16'h5555, 1'b0);
        check_result("gate_hold_1", 17'h00008, 1'b0);
        drive(1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
        check_result("gate_hold_2", 17'h00008, 1'b0);
    endtask

    // Scoreboard: each valid input pushes its sum; each cycle pops one.
    task automatic test_back_to_back();
        logic [15:0] x;
        logic [15:0] y;
        logic [16:0] e;
        for (int i = 0; i < 40; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            exp_q.push_back(ref_sum(x, y, 1'b0));
            drive(1'b1, x, y, 1'b0);
            e = exp_q.pop_front();
            check_result("back_to_back", e, 1'b1);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left, want 0", exp_q.size());
        end
    endtask

`ifdef ADDER_CIN_EN
    task automatic test_cin();
        logic [15:0] x;
        logic [15:0] y;
        logic        ci;
        drive(1'b1, 16'h7FFF, 16'h0000, 1'b1);
        check_result("cin_mid", 17'h08000, 1'b1);
        drive(1'b1, 16'hFFFF, 16'h0000, 1'b1);
        check_result("cin_wrap", 17'h10000, 1'b1);
        for (int i = 0; i < 30; i++) begin
            x  = 16'($urandom);
            y  = 16'($urandom);
            ci = 1'($urandom_range(0, 1));
            drive(1'b1, x, y, ci);
            check_result("cin_random", ref_sum(x, y, ci), 1'b1);
        end
    endtask
`endif

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = 16'h0;
        b        = 16'h0;
        cin      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_result("reset_state", 17'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        test_reset();
        test_random();
        test_carry_chain();
        test_maximum();
        test_valid_gating();
        test_back_to_back();
`ifdef ADDER_CIN_EN
        test_cin();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
